// File: rtl/xor_rr_sched.sv
// xor_rr_sched: round-robin arbiter that shares one registered XOR unit
// between two requesters and queues results in an in-order response FIFO.
// Ports:
//   clk, rst (sync, active-low)
//   reqN_valid/reqN_data[1:0]/reqN_ready : requester N operand handshake
//   xor_a, xor_b -> shared XOR unit, xor_out <- its result one cycle later
//   rsp_valid/rsp_data/rsp_id/rsp_ready  : response FIFO head handshake
//   busy : FSM not IDLE; gnt_cnt0/gnt_cnt1 : saturating grant counters
module xor_rr_sched #(
    parameter int RSP_DEPTH = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [1:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_data,
    output logic             req1_ready,
    output logic             xor_a,
    output logic             xor_b,
    input  logic             xor_out,
    output logic             rsp_valid,
    output logic             rsp_data,
    output logic             rsp_id,
    input  logic             rsp_ready,
    output logic             busy,
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0] LAST_C  = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          rr_ptr;
    logic [1:0]    op_reg;
    logic          id_reg;
    logic          gnt_id;
    logic          hs;
    logic          push;
    logic          pop;
    logic [1:0]    rsp_mem [RSP_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Requester picked this cycle: rr_ptr breaks ties.
    always_comb begin
        gnt_id = 1'b0;
        unique case ({req1_valid, req0_valid})
            2'b11:   gnt_id = rr_ptr;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = hs ? ISSUE : IDLE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is gated by rst so nothing leaks while in reset.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b0;
        if (rst) begin
            busy = (state != IDLE);
            if (state == IDLE && count < DEPTH_C) begin
                req0_ready = req0_valid && !gnt_id;
                req1_ready = req1_valid && gnt_id;
            end
        end
    end

    assign hs   = req0_ready || req1_ready;
    assign push = (state == WAIT);
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr   <= 1'b0;
            op_reg   <= 2'b00;
            id_reg   <= 1'b0;
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (hs) begin
            rr_ptr <= !gnt_id;
            op_reg <= gnt_id ? req1_data : req0_data;
            id_reg <= gnt_id;
            if (req0_ready && gnt_cnt0 != '1) begin
                gnt_cnt0 <= gnt_cnt0 + 1'b1;
            end
            if (req1_ready && gnt_cnt1 != '1) begin
                gnt_cnt1 <= gnt_cnt1 + 1'b1;
            end
        end
    end

    // Push only happens from WAIT, which needed room at accept time,
    // and pops only free space, so the FIFO cannot overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_C) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rsp_mem[wr_ptr] <= {id_reg, xor_out};
        end
    end

    assign xor_a     = rst && op_reg[1];
    assign xor_b     = rst && op_reg[0];
    assign rsp_valid = rst && (count != '0);
    assign rsp_id    = rsp_valid && rsp_mem[rd_ptr][1];
    assign rsp_data  = rsp_valid && rsp_mem[rd_ptr][0];

endmodule
